// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between four requesters. Each accepted
//   command is registered onto the ALU operand outputs. The ALU result is
//   captured one cycle later and then held as a response until the consumer
//   takes it. Only one command is in flight at a time. Requesters are served
//   round-robin, starting from the one after the last requester granted.
//
// Ports
//   clk, rst      single rising-edge clock, synchronous active-high reset
//   req_valid     per-requester command valid
//   req_a/req_b   packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_opsel     packed opcodes, requester i at [i*3 +: 3]
//   req_ready     one-hot grant, only in IDLE (combinational)
//   alu_a/alu_b/alu_opsel  registered command to the shared ALU
//   alu_result    combinational result returned by the shared ALU
//   rsp_valid/rsp_id/rsp_result  response held until rsp_ready
//   rsp_ready     response consumer ready
//   busy          high whenever the FSM is not IDLE
module alu_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MUL_WIDTH = 16,
    parameter int NUM_REQ   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_opsel,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_opsel,
    input  logic [MUL_WIDTH-1:0]     alu_result,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_id,
    output logic [MUL_WIDTH-1:0]     rsp_result,
    input  logic                     rsp_ready,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] last_grant;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       grant_any;
    logic       accept;

    // Round-robin search: offsets 1..4 from last_grant. Offset 4 wraps to
    // last_grant itself, so a lone requester is always found.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = last_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last_grant + 2'(k);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Grant is suppressed while rst is high, so that nothing is offered
    // during reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_any && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command capture, result capture and response handshake. RESP always
    // returns to IDLE before a new grant, which gives the 3-cycle minimum
    // issue interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 2'd3;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opsel  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            if (accept) begin
                alu_a      <= req_a[grant_idx*WIDTH +: WIDTH];
                alu_b      <= req_b[grant_idx*WIDTH +: WIDTH];
                alu_opsel  <= req_opsel[grant_idx*3 +: 3];
                last_grant <= grant_idx;
                rsp_id     <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_valid  <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule
